// File: rtl/aemb_mem_arb.sv
// Shares one single-port synchronous RAM between the aeMB IWB and DWB Wishbone masters.
// Optional statistics counters are enabled by defining AEMB_ARB_STAT_EN.
module aemb_mem_arb #(
    parameter int AW   = 16,
    parameter int MAXD = 2
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_o,
    input  logic [AW-1:0] iwb_adr_o,
    output logic          iwb_ack_i,
    output logic [31:0]   iwb_dat_i,
    input  logic          dwb_stb_o,
    input  logic          dwb_we_o,
    input  logic [3:0]    dwb_sel_o,
    input  logic [AW-1:0] dwb_adr_o,
    input  logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_i,
    output logic [31:0]   dwb_dat_i,
    output logic          mem_en_o,
    output logic [3:0]    mem_we_o,
    output logic [AW-3:0] mem_adr_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i
`ifdef AEMB_ARB_STAT_EN
    ,
    output logic [15:0]   arb_icnt_o,
    output logic [15:0]   arb_dcnt_o,
    output logic [15:0]   arb_wait_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GI,
        GD,
        AI,
        AD
    } state_e;

    localparam logic [3:0] MAXD_C = 4'(MAXD);

    state_e      state_q, state_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic        iack_q, iack_d;
    logic        dack_q, dack_d;
    logic        take_d;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{iwb_adr_o[1:0], dwb_adr_o[1:0]};

    // Data wins unless the instruction side has already been passed over MAXD times.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        take_d  = dwb_stb_o && (!iwb_stb_o || (dcnt_q < MAXD_C));
        case (state_q)
            IDLE: begin
                if (take_d) begin
                    state_d = GD;
                    dcnt_d  = iwb_stb_o ? dcnt_q + 4'd1 : 4'd0;
                end else if (iwb_stb_o) begin
                    state_d = GI;
                    dcnt_d  = 4'd0;
                end
            end
            GI:      state_d = AI;
            GD:      state_d = AD;
            AI, AD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        iack_d = (state_d == AI);
        dack_d = (state_d == AD);
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q <= IDLE;
            dcnt_q  <= 4'd0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            iack_q  <= iack_d;
            dack_q  <= dack_d;
        end
    end

    // Enables are gated by reset so a grant cycle hit by reset never commits a write.
    always_comb begin
        mem_en_o  = sys_rst_i && ((state_q == GI) || (state_q == GD));
        mem_we_o  = (sys_rst_i && (state_q == GD) && dwb_we_o) ? dwb_sel_o : 4'h0;
        mem_adr_o = (state_q == GI) ? iwb_adr_o[AW-1:2] : dwb_adr_o[AW-1:2];
        mem_dat_o = dwb_dat_o;
    end

    assign iwb_ack_i = iack_q;
    assign dwb_ack_i = dack_q;
    assign iwb_dat_i = mem_dat_i;
    assign dwb_dat_i = mem_dat_i;

`ifdef AEMB_ARB_STAT_EN
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] dgnt_q, dgnt_d;
    logic [15:0] wait_q, wait_d;
    logic        i_grant, d_grant, i_wait, d_wait;

    // A master is waiting when its strobe is high and it neither owns nor is just winning the RAM.
    always_comb begin
        i_grant = (state_q == IDLE) && (state_d == GI);
        d_grant = (state_q == IDLE) && (state_d == GD);
        i_wait  = iwb_stb_o && !i_grant && (state_q != GI) && (state_q != AI);
        d_wait  = dwb_stb_o && !d_grant && (state_q != GD) && (state_q != AD);
        icnt_d  = icnt_q + 16'(i_grant);
        dgnt_d  = dgnt_q + 16'(d_grant);
        wait_d  = wait_q + 16'(i_wait || d_wait);
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            icnt_q <= 16'd0;
            dgnt_q <= 16'd0;
            wait_q <= 16'd0;
        end else begin
            icnt_q <= icnt_d;
            dgnt_q <= dgnt_d;
            wait_q <= wait_d;
        end
    end

    assign arb_icnt_o = icnt_q;
    assign arb_dcnt_o = dgnt_q;
    assign arb_wait_o = wait_q;
`endif

endmodule
